fa_step4: RTL and testbench
===========================

# fa_step4

Final stage of the pipelined floating-point adder inside the MAC. It consumes the stage-3 Kogge-Stone prefix outputs (bit propagate `P0`, group generate `GG`) together with sign, exponent and subtract flag. It forms the 25-bit sum, normalizes it (overflow right shift or leading-zero left shift), adjusts the exponent, handles overflow/underflow and packs an IEEE-754 single-precision word. Two internal register stages; fully pipelined, one operation per cycle, no backpressure.

## Interface
- `MW`, 24: mantissa width including hidden bit; sum path is `MW+1`.
- `EW`, 8: exponent width.
- `CLK` in 1: clock, rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `in_valid` in 1: qualifies all other inputs this cycle.
- `in_sign` in 1: result sign.
- `in_yn` in 1: effective-subtraction flag; 1 = discard sum bit 24 (two's-complement wrap).
- `in_ex` in 8: pre-normalization exponent (biased).
- `P0` in 25: bit propagate (a XOR b).
- `in_GG` in 25: group generate; `in_GG[i]` = carry out of bit i.
- `out_valid` out 1: `out_result` and flags valid.
- `out_result` out 32: packed {sign, exp[7:0], frac[22:0]}.
- `out_ovf` out 1: exponent overflow, result forced to ±inf.
- `out_unf` out 1: exponent underflow, result flushed to ±0.
- `out_zero` out 1: exact zero sum.

## Operation
- Stage A (register A): `sum[24:0] = P0 ^ {in_GG[23:0], 1'b0}`; `in_GG[24]` ignored. If `in_yn`, force `sum[24]=0`. Register sum, sign, ex, valid.
- Stage B (register B), in priority order:
  1. `ex_A == 8'hFF`: result {sign, 8'hFF, 0}; no flags.
  2. `sum[24]==1` (add overflow): frac = `sum[23:1]`, exp = ex+1. If ex+1 == 255: result {sign, 8'hFF, 0}, `out_ovf=1`.
  3. `sum[23:0]==0`: result {0, 0, 0} (+0), `out_zero=1`.
  4. Otherwise `lz` = leading zeros of `sum[23:0]` (0..23). If `ex <= lz`: result {sign, 0, 0}, `out_unf=1`. Else exp = ex−lz, frac = `(sum[23:0] << lz)[22:0]`.
- Truncation only; no rounding, no subnormal output.
- Exponent arithmetic in 9 bits internally; compare before subtract.
- When `in_valid=0`, the bubble propagates. Data registers may hold stale values, but `out_valid=0`.

## Timing
- Latency 2 cycles: inputs sampled at edge N appear on outputs after edge N+2.
- Throughput 1/cycle; back-to-back valid inputs produce back-to-back valid outputs in order.
- Reset values: `out_valid=0`, `out_result=32'h0`, `out_ovf=0`, `out_unf=0`, `out_zero=0`; all internal stage-A registers 0.
- Reset asserted mid-operation clears both stages immediately (asynchronous). In-flight operations are lost, and no `out_valid` pulse appears for them after release.
- Flags are valid only when `out_valid=1`. They are registered together with `out_result`; they are never combinational.

## Structure
- Shared package `fp_mac_pkg`: `MW`, `EW`, `EXP_MAX=8'hFF`, `BIAS=127`, and the packed-float field widths. This package is shared with stages 1–3.
- Sub-module `lzc24`: combinational 24-bit leading-zero counter, 5-bit output, output 24 for all-zero input. Instantiated once in stage B.
- Everything else is inline in `fa_step4`.

## Test plan
- Plain add: in_valid=1, sign=0, yn=0, ex=127, P0=0, in_GG=25'h0400000 → after 2 cycles `out_result=32'h3F800000`, no flags.
- Add overflow: ex=127, P0=25'h1000000, in_GG=0, yn=0 → `32'h40000000`. Same input with ex=254 → `32'h7F800000`, `out_ovf=1`.
- Subtract with normalization: yn=1, ex=127, P0=25'h1400000, in_GG=0 → sum bit 24 dropped, lz=1 → `32'h3F000000`.
- Zero and underflow: P0=0, in_GG=0, sign=1 → `32'h00000000`, `out_zero=1`. Then ex=3, P0=25'h0000010 (lz=19), sign=1 → `32'h80000000`, `out_unf=1`.
- Pipeline and bubbles: inputs valid, invalid, valid over 3 consecutive cycles → `out_valid` shows 1,0,1 pattern two cycles later with matching results in order.
- Reset mid-flight: two valid inputs issued, RESET pulsed between edges before they exit → all outputs 0 immediately. After release, `out_valid` stays 0 until new input.

Source files
------------

// File: rtl/fp_mac_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | fp_mac_pkg : shared widths/constants for the FP MAC adder stages   |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
package fp_mac_pkg;

  localparam int MW        = 24;
  localparam int EW        = 8;
  localparam int FRAC_W    = 23;
  localparam int FP_W      = 1 + EW + FRAC_W;
  localparam int BIAS      = 127;
  localparam logic [7:0] EXP_MAX = 8'hFF;

  typedef struct packed {
    logic              sign;
    logic [EW-1:0]     exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

endpackage

`default_nettype wire

// File: rtl/fa_step4_lzc24.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | lzc24 : combinational 24-bit leading-zero counter (24 for zero)    |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
module lzc24 (
  input  logic [23:0] i_data,
  output logic [4:0]  o_lz
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    o_lz = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (i_data[i]) o_lz = 5'(23 - i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fa_step4.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | fa_step4 : FP adder final stage - sum, normalize, pack (2 stages)  |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
module fa_step4
  import fp_mac_pkg::*;
#(
  parameter int MW = fp_mac_pkg::MW,
  parameter int EW = fp_mac_pkg::EW
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          in_valid,
  input  logic          in_sign,
  input  logic          in_yn,
  input  logic [EW-1:0] in_ex,
  input  logic [MW:0]   P0,
  input  logic [MW:0]   in_GG,
  output logic          out_valid,
  output logic [31:0]   out_result,
  output logic          out_ovf,
  output logic          out_unf,
  output logic          out_zero
);

  logic [MW:0]   w_sum;
  logic          w_unused_gg;

  logic          r_a_valid;
  logic          r_a_sign;
  logic [EW-1:0] r_a_ex;
  logic [MW:0]   r_a_sum;

  logic [4:0]    w_lz;
  logic [EW:0]   w_ex9;
  logic [EW:0]   w_lz9;
  logic [EW:0]   w_ex_inc;
  logic [EW-1:0] w_ex_dec;
  logic [MW-2:0] w_frac_norm;

  fp32_t         w_res;
  logic          w_ovf;
  logic          w_unf;
  logic          w_zero;

  logic          r_out_valid;
  logic [31:0]   r_out_result;
  logic          r_out_ovf;
  logic          r_out_unf;
  logic          r_out_zero;

  // Carry into bit i is the group generate of bit i-1; the top carry is dropped.
  always_comb begin
    w_sum = P0 ^ {in_GG[MW-1:0], 1'b0};
    if (in_yn) w_sum[MW] = 1'b0;
  end
  assign w_unused_gg = in_GG[MW];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_a_valid <= 1'b0;
      r_a_sign  <= 1'b0;
      r_a_ex    <= '0;
      r_a_sum   <= '0;
    end else begin
      r_a_valid <= in_valid;
      r_a_sign  <= in_sign;
      r_a_ex    <= in_ex;
      r_a_sum   <= w_sum;
    end
  end

  lzc24 u_lzc (
    .i_data (r_a_sum[MW-1:0]),
    .o_lz   (w_lz)
  );

  assign w_ex9       = {1'b0, r_a_ex};
  assign w_lz9       = {{(EW-4){1'b0}}, w_lz};
  assign w_ex_inc    = w_ex9 + 1'b1;
  assign w_ex_dec    = r_a_ex - w_lz9[EW-1:0];
  // Bit MW-1 of the normalized mantissa is the hidden one, so it is never kept.
  assign w_frac_norm = r_a_sum[MW-2:0] << w_lz;

  always_comb begin
    w_res  = '0;
    w_ovf  = 1'b0;
    w_unf  = 1'b0;
    w_zero = 1'b0;
    if (r_a_ex == EXP_MAX) begin
      w_res.sign = r_a_sign;
      w_res.exp  = EXP_MAX;
    end else if (r_a_sum[MW]) begin
      w_res.sign = r_a_sign;
      if (w_ex_inc == {1'b0, EXP_MAX}) begin
        w_res.exp = EXP_MAX;
        w_ovf     = 1'b1;
      end else begin
        w_res.exp  = w_ex_inc[EW-1:0];
        w_res.frac = r_a_sum[MW-1:1];
      end
    end else if (r_a_sum[MW-1:0] == '0) begin
      w_zero = 1'b1;
    end else if (w_ex9 <= w_lz9) begin
      w_res.sign = r_a_sign;
      w_unf      = 1'b1;
    end else begin
      w_res.sign = r_a_sign;
      w_res.exp  = w_ex_dec;
      w_res.frac = w_frac_norm;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_ovf    <= 1'b0;
      r_out_unf    <= 1'b0;
      r_out_zero   <= 1'b0;
    end else begin
      r_out_valid  <= r_a_valid;
      r_out_result <= w_res;
      r_out_ovf    <= w_ovf;
      r_out_unf    <= w_unf;
      r_out_zero   <= w_zero;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_ovf    = r_out_ovf;
  assign out_unf    = r_out_unf;
  assign out_zero   = r_out_zero;

endmodule

`default_nettype wire

// File: tb/tb_fa_step4.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_fa_step4 : scoreboard bench with directed vectors for fa_step4  |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
module tb_fa_step4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sign = 1'b0;
  logic        in_yn = 1'b0;
  logic [7:0]  in_ex = '0;
  logic [24:0] P0 = '0;
  logic [24:0] in_GG = '0;
  logic        out_valid;
  logic [31:0] out_result;
  logic        out_ovf;
  logic        out_unf;
  logic        out_zero;

  typedef struct {
    bit          v;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        zero;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  fa_step4 dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .in_valid   (in_valid),
    .in_sign    (in_sign),
    .in_yn      (in_yn),
    .in_ex      (in_ex),
    .P0         (P0),
    .in_GG      (in_GG),
    .out_valid  (out_valid),
    .out_result (out_result),
    .out_ovf    (out_ovf),
    .out_unf    (out_unf),
    .out_zero   (out_zero)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the oldest due entry.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        chk("valid", {31'b0, out_valid}, {31'b0, e.v});
        if (e.v && out_valid) begin
          chk("result", out_result, e.res);
          chk("ovf", {31'b0, out_ovf}, {31'b0, e.ovf});
          chk("unf", {31'b0, out_unf}, {31'b0, e.unf});
          chk("zero", {31'b0, out_zero}, {31'b0, e.zero});
        end
      end else begin
        chk("idle_valid", {31'b0, out_valid}, 32'd0);
      end
    end
  end

  task automatic drive(input bit v, input bit s, input bit yn, input logic [7:0] ex,
                       input logic [24:0] p0, input logic [24:0] gg,
                       input logic [31:0] res, input bit ovf, input bit unf, input bit zero);
    exp_t e;
    @(negedge CLK);
    in_valid = v; in_sign = s; in_yn = yn; in_ex = ex; P0 = p0; in_GG = gg;
    e.v = v; e.res = res; e.ovf = ovf; e.unf = unf; e.zero = zero; e.due = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      in_valid = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_flags", {29'b0, out_ovf, out_unf, out_zero}, 32'd0);
    RESET = 1'b0;

    //     v  s  yn ex      P0           GG           result        ovf unf zero
    drive(1, 0, 0, 8'd127, 25'h0000000, 25'h0400000, 32'h3F800000, 0, 0, 0);
    drive(1, 0, 0, 8'd127, 25'h1000000, 25'h0000000, 32'h40000000, 0, 0, 0);
    drive(1, 0, 0, 8'd254, 25'h1000000, 25'h0000000, 32'h7F800000, 1, 0, 0);
    drive(1, 0, 1, 8'd127, 25'h1400000, 25'h0000000, 32'h3F000000, 0, 0, 0);
    drive(1, 1, 0, 8'd127, 25'h0000000, 25'h0000000, 32'h00000000, 0, 0, 1);
    drive(1, 1, 0, 8'd3,   25'h0000010, 25'h0000000, 32'h80000000, 0, 1, 0);
    drive(1, 1, 0, 8'hFF,  25'h0800000, 25'h0000000, 32'hFF800000, 0, 0, 0);
    drive(1, 0, 0, 8'd130, 25'h0C00000, 25'h0000000, 32'h41400000, 0, 0, 0);
    drive(1, 0, 0, 8'd30,  25'h0000003, 25'h0000001, 32'h03800000, 0, 0, 0);
    drive(1, 0, 0, 8'd23,  25'h0000001, 25'h0000000, 32'h00000000, 0, 1, 0);
    drive(1, 0, 0, 8'd24,  25'h0000001, 25'h0000000, 32'h00800000, 0, 0, 0);
    drive(1, 0, 0, 8'd100, 25'h1800002, 25'h0000000, 32'h32C00001, 0, 0, 0);
    drive(1, 0, 0, 8'd127, 25'h0800000, 25'h1000000, 32'h3F800000, 0, 0, 0);
    drive(1, 0, 0, 8'd127, 25'h0800000, 25'h0800000, 32'h40400000, 0, 0, 0);
    drive(1, 0, 1, 8'd127, 25'h0800000, 25'h0800000, 32'h3F800000, 0, 0, 0);
    drive(1, 1, 0, 8'd254, 25'h0800000, 25'h0000000, 32'hFF000000, 0, 0, 0);
    // Bubble sandwich: valid, invalid, valid.
    drive(1, 0, 0, 8'd128, 25'h0A00000, 25'h0000000, 32'h40200000, 0, 0, 0);
    drive(0, 1, 0, 8'd127, 25'h0800000, 25'h0000000, 32'h00000000, 0, 0, 0);
    drive(1, 1, 0, 8'd126, 25'h0800000, 25'h0000000, 32'hBF000000, 0, 0, 0);
    idle(4);

    // Reset while two operations are in flight, just after a result emerged.
    drive(1, 0, 0, 8'd127, 25'h0C00000, 25'h0000000, 32'h3FC00000, 0, 0, 0);
    drive(1, 0, 0, 8'd127, 25'h0800000, 25'h0000000, 32'h3F800000, 0, 0, 0);
    drive(1, 0, 0, 8'd128, 25'h0800000, 25'h0000000, 32'h40000000, 0, 0, 0);
    #1;
    RESET = 1'b1;
    sb.delete();
    in_valid = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_result", out_result, 32'd0);
    chk("midrst_flags", {29'b0, out_ovf, out_unf, out_zero}, 32'd0);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    idle(6);

    drive(1, 0, 0, 8'd129, 25'h0800000, 25'h0000000, 32'h40800000, 0, 0, 0);
    idle(4);
    chk("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
